// File: rtl/tt6581_pkg.sv
// Shared TT6581 datapath types and constants.
// Holds the multiplier arbiter state encoding, client indices and default operand widths.
package tt6581_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } mult_arb_state_e;

    localparam int unsigned MREQ_ENV = 0;
    localparam int unsigned MREQ_SVF = 1;
    localparam int unsigned MREQ_VOL = 2;

    localparam int unsigned MULT_A_W = 16;
    localparam int unsigned MULT_B_W = 16;

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational request picker: first set request at or after ptr (wrapping) when rr_en,
// otherwise the lowest set index. Outputs a one-hot grant and its index.
module mult_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W:0]   start;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] sel;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        sel   = '0;
        start = rr_en ? {1'b0, ptr} : '0;
        // Scan N positions starting at the pointer; the wrap is a single subtract since start < N.
        for (int unsigned i = 0; i < N; i++) begin
            cand = start + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            sel = cand[IDX_W-1:0];
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin / fixed-priority owner of the shared signed multiplier: grants one client,
// issues the operands, waits for ready under a timeout watchdog and returns the product.
module mult_arbiter
    import tt6581_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned A_W     = MULT_A_W,
    parameter int unsigned B_W     = MULT_B_W,
    parameter int unsigned TIMEOUT = 64,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0][A_W-1:0]     op_a_i,
    input  logic [N_REQ-1:0][B_W-1:0]     op_b_i,
    output logic [N_REQ-1:0]              grant_o,
    output logic [N_REQ-1:0]              done_o,
    output logic                          err_o,
    output logic [A_W+B_W-1:0]            result_o,
    output logic                          busy_o,
    output logic                          mult_start_o,
    output logic [A_W-1:0]                mult_a_o,
    output logic [B_W-1:0]                mult_b_o,
    input  logic                          mult_ready_i,
    input  logic [A_W+B_W-1:0]            mult_p_i
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam int unsigned P_W   = A_W + B_W;

    mult_arb_state_e  state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_REQ-1:0] grant_d, done_d;
    logic             err_d, busy_d, start_d;
    logic [P_W-1:0]   result_d;
    logic [A_W-1:0]   a_d;
    logic [B_W-1:0]   b_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;

    mult_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .rr_en (RR_EN),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rr_ptr_d = rr_ptr;
        idx_d    = idx_q;
        grant_d  = grant_o;
        done_d   = done_o;
        err_d    = err_o;
        result_d = result_o;
        start_d  = mult_start_o;
        a_d      = mult_a_o;
        b_d      = mult_b_o;

        unique case (state)
            IDLE: begin
                if (|req_i) begin
                    idx_d   = pick_idx;
                    grant_d = pick_gnt;
                    a_d     = op_a_i[pick_idx];
                    b_d     = op_b_i[pick_idx];
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_d = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready takes precedence over the final watchdog cycle.
                if (mult_ready_i) begin
                    result_d = mult_p_i;
                    done_d   = grant_o;
                    state_d  = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    done_d   = grant_o;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                grant_d  = '0;
                done_d   = '0;
                err_d    = 1'b0;
                rr_ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            idx_q        <= '0;
            grant_o      <= '0;
            done_o       <= '0;
            err_o        <= 1'b0;
            result_o     <= '0;
            busy_o       <= 1'b0;
            mult_start_o <= 1'b0;
            mult_a_o     <= '0;
            mult_b_o     <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rr_ptr       <= rr_ptr_d;
            idx_q        <= idx_d;
            grant_o      <= grant_d;
            done_o       <= done_d;
            err_o        <= err_d;
            result_o     <= result_d;
            busy_o       <= busy_d;
            mult_start_o <= start_d;
            mult_a_o     <= a_d;
            mult_b_o     <= b_d;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: round-robin instance driven by a scripted multiplier,
// plus a fixed-priority instance checked for lowest-index wins.
module tb_mult_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    logic [2:0]       req;
    logic [2:0][15:0] op_a, op_b;
    logic [2:0]       grant, done;
    logic             err, busy, mstart, mready;
    logic [31:0]      result, mp;
    logic [15:0]      ma, mb;

    logic [2:0]       fx_req, fx_grant, fx_done;
    logic             fx_err, fx_busy, fx_start, fx_ready;
    logic [31:0]      fx_result;
    logic [15:0]      fx_ma, fx_mb;

    int n_checks = 0;
    int n_pass   = 0;

    mult_arbiter #(
        .N_REQ   (3),
        .A_W     (16),
        .B_W     (16),
        .TIMEOUT (64),
        .RR_EN   (1'b1)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .grant_o      (grant),
        .done_o       (done),
        .err_o        (err),
        .result_o     (result),
        .busy_o       (busy),
        .mult_start_o (mstart),
        .mult_a_o     (ma),
        .mult_b_o     (mb),
        .mult_ready_i (mready),
        .mult_p_i     (mp)
    );

    mult_arbiter #(
        .N_REQ   (3),
        .A_W     (16),
        .B_W     (16),
        .TIMEOUT (64),
        .RR_EN   (1'b0)
    ) u_fx (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (fx_req),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .grant_o      (fx_grant),
        .done_o       (fx_done),
        .err_o        (fx_err),
        .result_o     (fx_result),
        .busy_o       (fx_busy),
        .mult_start_o (fx_start),
        .mult_a_o     (fx_ma),
        .mult_b_o     (fx_mb),
        .mult_ready_i (fx_ready),
        .mult_p_i     (32'd0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".grant"},  32'(grant),  32'd0);
        check_eq({tag, ".done"},   32'(done),   32'd0);
        check_eq({tag, ".err"},    32'(err),    32'd0);
        check_eq({tag, ".result"}, result,      32'd0);
        check_eq({tag, ".busy"},   32'(busy),   32'd0);
        check_eq({tag, ".start"},  32'(mstart), 32'd0);
        check_eq({tag, ".ma"},     32'(ma),     32'd0);
        check_eq({tag, ".mb"},     32'(mb),     32'd0);
    endtask

    // ISSUE cycle, lat WAIT cycles (ready in WAIT cycle lat; lat=0 never), DONE, IDLE.
    task automatic run_op(input string tag, input logic [2:0] exp_gnt, input int lat,
                          input logic [31:0] exp_res, input logic exp_err,
                          input logic [2:0] req_after, input bit scramble);
        @(negedge clk);
        check_eq({tag, ".issue_grant"}, 32'(grant),  32'(exp_gnt));
        check_eq({tag, ".issue_start"}, 32'(mstart), 32'd1);
        check_eq({tag, ".issue_busy"},  32'(busy),   32'd1);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            check_eq({tag, ".wait_done"}, 32'(done), 32'd0);
            if (i == 1) begin
                check_eq({tag, ".wait_start"}, 32'(mstart), 32'd0);
                if (scramble) begin
                    op_a = {3{16'h0007}};
                    op_b = {3{16'h0009}};
                    req  = '0;
                end
            end
            if (i == lat) begin
                mready = 1'b1;
                mp = $signed({{16{ma[15]}}, ma}) * $signed({{16{mb[15]}}, mb});
                break;
            end
        end
        @(negedge clk);
        mready = 1'b0;
        check_eq({tag, ".done"},       32'(done),  32'(exp_gnt));
        check_eq({tag, ".err"},        32'(err),   32'(exp_err));
        check_eq({tag, ".result"},     result,     exp_res);
        check_eq({tag, ".done_grant"}, 32'(grant), 32'(exp_gnt));
        req = req_after;
        @(negedge clk);
        check_eq({tag, ".idle_grant"}, 32'(grant), 32'd0);
        check_eq({tag, ".idle_done"},  32'(done),  32'd0);
        check_eq({tag, ".idle_err"},   32'(err),   32'd0);
        check_eq({tag, ".idle_busy"},  32'(busy),  32'd0);
    endtask

    logic [2:0]  rr_g   [3];
    logic [31:0] rr_res [3];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; mready = 1'b0; mp = '0;
        fx_req = '0; fx_ready = 1'b0;
        rr_g   = '{3'b001, 3'b010, 3'b100};
        rr_res = '{32'hFFFF_FFEC, 32'hFFFF_FFD8, 32'hFFFF_FFC4};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check_eq("fx_reset.grant",  32'(fx_grant), 32'd0);
        check_eq("fx_reset.done",   32'(fx_done),  32'd0);
        check_eq("fx_reset.err",    32'(fx_err),   32'd0);
        check_eq("fx_reset.result", fx_result,     32'd0);
        check_eq("fx_reset.busy",   32'(fx_busy),  32'd0);
        check_eq("fx_reset.start",  32'(fx_start), 32'd0);
        check_eq("fx_reset.ma",     32'(fx_ma),    32'd0);
        check_eq("fx_reset.mb",     32'(fx_mb),    32'd0);
        rst_n = 1'b1;

        // -300 * 200 = -60000
        @(negedge clk);
        op_a[0] = 16'hFED4; op_b[0] = 16'd200; req = 3'b001;
        run_op("single", 3'b001, 4, 32'hFFFF_15A0, 1'b0, 3'b000, 1'b0);

        // Fresh reset, then all clients held high: grants 0,1,2,0,1,2.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_a[0] = 16'd10; op_a[1] = 16'd20; op_a[2] = 16'd30;
        op_b = {3{16'hFFFE}};
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            run_op($sformatf("rr%0d", k), rr_g[k % 3], 1, rr_res[k % 3], 1'b0,
                   (k == 5) ? 3'b000 : 3'b111, 1'b0);
        end

        // 1234 * -5 = -6170; operands and request change during WAIT.
        op_a[2] = 16'd1234; op_b[2] = 16'hFFFB; req = 3'b100;
        run_op("latch", 3'b100, 3, 32'hFFFF_E7E6, 1'b0, 3'b000, 1'b1);

        req = 3'b010;
        run_op("timeout", 3'b010, 0, 32'h0000_0000, 1'b1, 3'b000, 1'b0);

        // 3 * -7 = -21, ready in the last WAIT cycle.
        op_a[1] = 16'd3; op_b[1] = 16'hFFF9; req = 3'b010;
        run_op("ready_w64", 3'b010, 64, 32'hFFFF_FFEB, 1'b0, 3'b000, 1'b0);

        op_a[0] = 16'h8000; op_b[0] = 16'h8000; req = 3'b001;
        run_op("ext_nn", 3'b001, 2, 32'h4000_0000, 1'b0, 3'b000, 1'b0);
        op_b[0] = 16'h7FFF; req = 3'b001;
        run_op("ext_np", 3'b001, 2, 32'hC000_8000, 1'b0, 3'b000, 1'b0);

        // Reset during WAIT, then a stale ready must not complete anything.
        req = 3'b010;
        @(negedge clk);
        check_eq("rst_mid.issue_grant", 32'(grant), 32'(3'b010));
        repeat (2) @(negedge clk);
        req = '0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mready = 1'b1; mp = 32'h1234_5678;
        @(negedge clk);
        mready = 1'b0;
        check_eq("late_ready.done",   32'(done), 32'd0);
        check_eq("late_ready.busy",   32'(busy), 32'd0);
        check_eq("late_ready.result", result,    32'd0);
        op_a[0] = 16'd5; op_a[1] = 16'd6; op_a[2] = 16'd7;
        op_b = {3{16'd3}};
        req = 3'b111;
        run_op("post_rst", 3'b001, 1, 32'd15, 1'b0, 3'b000, 1'b0);

        // Fixed priority: client 0 wins every time while all request.
        fx_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("fx%0d.grant", k), 32'(fx_grant), 32'(3'b001));
            check_eq($sformatf("fx%0d.start", k), 32'(fx_start), 32'd1);
            @(negedge clk);
            fx_ready = 1'b1;
            @(negedge clk);
            fx_ready = 1'b0;
            check_eq($sformatf("fx%0d.done", k), 32'(fx_done), 32'(3'b001));
            @(negedge clk);
            check_eq($sformatf("fx%0d.idle_grant", k), 32'(fx_grant), 32'd0);
        end
        fx_req = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
